target_manager: RTL and testbench

Consumer and controller for the LFSR target generator in the snake game datapath. Seeds the generator and pulses its trigger. Filters the free-running candidate stream down to on-screen coordinates that do not coincide with the snake head. Holds the accepted target, detects when the head reaches it, issues a hit pulse, requests the next target, and (optionally) keeps score.

---
 rtl/target_pkg.sv | 9 +
 rtl/target_manager_if.sv | 26 ++
 rtl/target_candidate_check.sv | 20 ++
 rtl/target_manager.sv | 119 +++++++++++
 tb/tb_target_manager.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/target_pkg.sv
// Shared types and constants for the snake-game target manager.
package target_pkg;
   typedef enum logic [1:0] {IDLE, SEED, SAMPLE, ARMED} state_t;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
endpackage

// File: rtl/target_manager_if.sv
// Handshake/data bundle between the target manager, the LFSR generator and the snake datapath.
interface target_manager_if;
   logic                         start;
   logic [target_pkg::X_W-1:0]   head_x;
   logic [target_pkg::Y_W-1:0]   head_y;
   logic                         head_valid;
   logic [target_pkg::X_W-1:0]   rand_num_X;
   logic [target_pkg::Y_W-1:0]   rand_num_Y;
   logic                         gen_triger;
   logic [15:0]                  gen_seed;
   logic [target_pkg::X_W-1:0]   target_x;
   logic [target_pkg::Y_W-1:0]   target_y;
   logic                         target_valid;
   logic                         hit;
   logic [7:0]                   score;

   modport slave (
      input  start, head_x, head_y, head_valid, rand_num_X, rand_num_Y,
      output gen_triger, gen_seed, target_x, target_y, target_valid, hit, score
   );

   modport master (
      output start, head_x, head_y, head_valid, rand_num_X, rand_num_Y,
      input  gen_triger, gen_seed, target_x, target_y, target_valid, hit, score
   );
endinterface

// File: rtl/target_candidate_check.sv
// Combinational accept decision for one generator candidate: on screen and not under the snake head.
module target_candidate_check
   import target_pkg::*;
#(
   parameter int X_MAX = SCREEN_W,
   parameter int Y_MAX = SCREEN_H
) (
   input  logic [X_W-1:0] cand_x_i,
   input  logic [Y_W-1:0] cand_y_i,
   input  logic [X_W-1:0] head_x_i,
   input  logic [Y_W-1:0] head_y_i,
   output logic           accept_o
);
   logic in_range;
   logic on_head;

   assign in_range = (int'(cand_x_i) < X_MAX) && (int'(cand_y_i) < Y_MAX);
   assign on_head  = (cand_x_i == head_x_i) && (cand_y_i == head_y_i);
   assign accept_o = in_range && !on_head;
endmodule

// File: rtl/target_manager.sv
// Seeds/filters the LFSR target stream, arms a target, reports hits. Optional score counter
// behind macro TARGET_SCORE_EN (undefined: score reads 0).
module target_manager
   import target_pkg::*;
#(
   parameter int X_MAX     = SCREEN_W,
   parameter int Y_MAX     = SCREEN_H,
   parameter int MAX_TRIES = 32
) (
   input  logic          CLK,
   input  logic          RESET,
   target_manager_if.slave bus
);
   localparam logic [X_W-1:0] FALLBACK_X = X_W'(X_MAX / 2);
   localparam logic [Y_W-1:0] FALLBACK_Y = Y_W'(Y_MAX / 2);
   localparam logic [7:0]     TRIES_LAST = 8'(MAX_TRIES - 1);

   state_t         state_q;
   logic [15:0]    seed_cnt_q;
   logic [7:0]     tries_q;
   logic           trig_q;
   logic           hit_q;
   logic           tv_q;
   logic [X_W-1:0] tx_q;
   logic [Y_W-1:0] ty_q;
   logic           accept;
   logic           restart;
   logic           hit_now;

   target_candidate_check #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_check (
      .cand_x_i (bus.rand_num_X),
      .cand_y_i (bus.rand_num_Y),
      .head_x_i (bus.head_x),
      .head_y_i (bus.head_y),
      .accept_o (accept)
   );

   // A start seen while already seeding is absorbed so the trigger never stretches to two cycles.
   assign restart = bus.start && (state_q != SEED);
   assign hit_now = !restart && (state_q == ARMED) && bus.head_valid &&
                    (bus.head_x == tx_q) && (bus.head_y == ty_q);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         seed_cnt_q <= 16'd0;
         tries_q    <= 8'd0;
         trig_q     <= 1'b0;
         hit_q      <= 1'b0;
         tv_q       <= 1'b0;
         tx_q       <= '0;
         ty_q       <= '0;
      end else begin
         seed_cnt_q <= seed_cnt_q + 16'd1;
         trig_q     <= 1'b0;
         hit_q      <= 1'b0;
         if (restart) begin
            state_q <= SEED;
            trig_q  <= 1'b1;
            tv_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: state_q <= IDLE;
               SEED: begin
                  tries_q <= 8'd0;
                  state_q <= SAMPLE;
               end
               SAMPLE: begin
                  if (accept) begin
                     tx_q    <= bus.rand_num_X;
                     ty_q    <= bus.rand_num_Y;
                     tv_q    <= 1'b1;
                     state_q <= ARMED;
                  end else begin
                     tries_q <= tries_q + 8'd1;
                     if (tries_q == TRIES_LAST) begin
                        tx_q    <= FALLBACK_X;
                        ty_q    <= FALLBACK_Y;
                        tv_q    <= 1'b1;
                        state_q <= ARMED;
                     end
                  end
               end
               ARMED: begin
                  if (hit_now) begin
                     hit_q   <= 1'b1;
                     tv_q    <= 1'b0;
                     tries_q <= 8'd0;
                     state_q <= SAMPLE;
                  end
               end
            endcase
         end
      end
   end

`ifdef TARGET_SCORE_EN
   logic [7:0] score_q;

   always_ff @(posedge CLK) begin
      if (RESET || restart)
         score_q <= 8'd0;
      else if (hit_now && (score_q != 8'hFF))
         score_q <= score_q + 8'd1;
   end

   assign bus.score = score_q;
`else
   assign bus.score = 8'h00;
`endif

   // Forcing bit 0 keeps the LFSR out of its all-zero lock-up state.
   assign bus.gen_seed     = seed_cnt_q | 16'h0001;
   assign bus.gen_triger   = trig_q;
   assign bus.hit          = hit_q;
   assign bus.target_valid = tv_q;
   assign bus.target_x     = tx_q;
   assign bus.target_y     = ty_q;
endmodule

// File: tb/tb_target_manager.sv
// Directed bench for target_manager (MAX_TRIES = 4) with a cycle-level reference model.
module tb_target_manager;
   import target_pkg::*;

   localparam int XM = 160;
   localparam int YM = 120;
   localparam int MT = 4;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   target_manager_if bus();

   target_manager #(.X_MAX(XM), .Y_MAX(YM), .MAX_TRIES(MT)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Reference model: game phase as a string, plain arithmetic for everything else.
   string   m_phase = "idle";
   int      m_cycles = 0;
   int      m_misses = 0;
   int      m_tx = 0, m_ty = 0, m_score = 0;
   bit      m_tv = 0, m_hit = 0, m_trig = 0;

   function automatic int exp_score(int hits);
`ifdef TARGET_SCORE_EN
      return (hits > 255) ? 255 : hits;
`else
      return 0;
`endif
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK) begin
      bit ok;
      if (RESET) begin
         m_phase = "idle"; m_cycles = 0; m_misses = 0;
         m_tx = 0; m_ty = 0; m_score = 0; m_tv = 0; m_hit = 0; m_trig = 0;
      end else begin
         m_cycles = (m_cycles + 1) % 65536;
         m_hit = 0;
         m_trig = 0;
         if (bus.start && m_phase != "seed") begin
            m_phase = "seed"; m_trig = 1; m_tv = 0; m_score = 0;
         end else if (m_phase == "seed") begin
            m_phase = "sample"; m_misses = 0;
         end else if (m_phase == "sample") begin
            ok = (int'(bus.rand_num_X) < XM) && (int'(bus.rand_num_Y) < YM) &&
                 !(bus.rand_num_X == bus.head_x && bus.rand_num_Y == bus.head_y);
            if (ok) begin
               m_tx = bus.rand_num_X; m_ty = bus.rand_num_Y; m_tv = 1; m_phase = "armed";
            end else begin
               m_misses++;
               if (m_misses >= MT) begin
                  m_tx = XM / 2; m_ty = YM / 2; m_tv = 1; m_phase = "armed";
               end
            end
         end else if (m_phase == "armed") begin
            if (bus.head_valid && int'(bus.head_x) == m_tx && int'(bus.head_y) == m_ty) begin
               m_hit = 1; m_tv = 0; m_misses = 0; m_phase = "sample";
`ifdef TARGET_SCORE_EN
               if (m_score < 255) m_score++;
`endif
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (cmp_en) begin
         check("gen_triger",   bus.gen_triger,   m_trig);
         check("gen_seed",     bus.gen_seed,     (m_cycles | 1));
         check("target_valid", bus.target_valid, m_tv);
         check("target_x",     bus.target_x,     m_tx);
         check("target_y",     bus.target_y,     m_ty);
         check("hit",          bus.hit,          m_hit);
         check("score",        bus.score,        m_score);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_cand(int x, int y);
      bus.rand_num_X = 8'(x);
      bus.rand_num_Y = 7'(y);
   endtask

   task automatic set_head(int x, int y, bit v);
      bus.head_x     = 8'(x);
      bus.head_y     = 7'(y);
      bus.head_valid = v;
   endtask

   initial begin
      RESET = 1'b1;
      bus.start = 1'b0;
      set_head(0, 0, 0);
      set_cand(40, 30);
      step();
      step();
      cmp_en = 1'b1;
      RESET = 1'b0;

      // Reset values
      check("rst_gen_seed", bus.gen_seed, 16'h0001);
      check("rst_trig", bus.gen_triger, 0);
      check("rst_tv", bus.target_valid, 0);
      check("rst_score", bus.score, 0);

      // Start sequence: cycle 0 start, cycle 1 trigger, cycle 3 target
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("c1_trig", bus.gen_triger, 1);
      step();
      check("c2_trig", bus.gen_triger, 0);
      check("c2_tv", bus.target_valid, 0);
      step();
      check("c3_tv", bus.target_valid, 1);
      check("c3_tx", bus.target_x, 40);
      check("c3_ty", bus.target_y, 30);
      check("c3_score", bus.score, 0);

      // Hit, then two rejects and an accept
      set_head(40, 30, 1);
      step();
      check("hit1_pulse", bus.hit, 1);
      check("hit1_tv", bus.target_valid, 0);
      check("hit1_score", bus.score, exp_score(1));
      set_head(40, 30, 0);
      set_cand(200, 10);
      step();
      check("hit1_off", bus.hit, 0);
      set_cand(10, 125);
      step();
      set_cand(50, 60);
      step();
      check("rej_tv", bus.target_valid, 1);
      check("rej_tx", bus.target_x, 50);
      check("rej_ty", bus.target_y, 60);

      // Matching head without head_valid is ignored
      set_head(50, 60, 0);
      step();
      step();
      check("nohit", bus.hit, 0);
      check("nohit_tv", bus.target_valid, 1);
      set_head(50, 60, 1);
      step();
      check("hit2_pulse", bus.hit, 1);
      check("hit2_score", bus.score, exp_score(2));

      // Candidate on the head is rejected
      set_head(20, 20, 0);
      set_cand(20, 20);
      step();
      check("onhead_tv", bus.target_valid, 0);
      set_cand(30, 40);
      step();
      check("onhead_next_tx", bus.target_x, 30);
      check("onhead_next_tv", bus.target_valid, 1);

      // Fallback after MAX_TRIES out-of-range candidates
      set_head(30, 40, 1);
      set_cand(255, 10);
      step();
      set_head(30, 40, 0);
      step();
      step();
      step();
      check("fb_tv_pre", bus.target_valid, 0);
      step();
      check("fb_tv", bus.target_valid, 1);
      check("fb_tx", bus.target_x, 80);
      check("fb_ty", bus.target_y, 60);

      // Start wins over a simultaneous hit
      set_head(80, 60, 1);
      bus.start = 1'b1;
      step();
      check("sh_hit", bus.hit, 0);
      check("sh_score", bus.score, 0);
      check("sh_trig", bus.gen_triger, 1);
      bus.start = 1'b0;
      set_head(0, 0, 0);
      set_cand(40, 30);
      step();
      step();
      check("sh_tv", bus.target_valid, 1);
      check("sh_tx", bus.target_x, 40);

      // Score saturation
      for (int i = 0; i < 256; i++) begin
         set_head(m_tx, m_ty, 1);
         step();
         set_head(m_tx, m_ty, 0);
         if (i % 2 == 0) set_cand(11, 10);
         else            set_cand(10, 10);
         step();
         step();
      end
      check("sat_score", bus.score, exp_score(256));
      check("sat_tv", bus.target_valid, 1);

      step();
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
